// File: rtl/puf_dump_ctrl.sv
// SRAM-PUF readout controller: on a UART start command, streams the RAM power-up content
// byte by byte (little-endian lanes) over the UART TX, with an optional trailing XOR checksum.
module puf_dump_ctrl #(
    parameter int         ADDR_W    = 13,
    parameter int         DATA_W    = 16,
    parameter int         NUM_WORDS = 8192,
    parameter logic [7:0] CMD_START = 8'h73,
    parameter logic [7:0] CMD_ABORT = 8'h78,
    parameter bit         CSUM_EN   = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx_ready,
    input  logic [7:0]        uart_data_from_rx,
    input  logic              uart_tx_ready,
    output logic [7:0]        uart_data_to_tx,
    output logic              uart_tx_enable,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              done
);
    localparam int L      = DATA_W / 8;
    localparam int NB     = NUM_WORDS * L;
    localparam int IDX_W  = $clog2(NB) + 1;
    localparam int LANE_W = (L > 1) ? $clog2(L) : 1;

    typedef enum logic [3:0] {
        INIT, IDLE, RD_ADDR, RD_WAIT, LOAD, SEND, WAIT_FIN, NEXT, CSUM, CSUM_WAIT
    } state_t;

    state_t            state, state_nx;
    logic [IDX_W-1:0]  byte_idx;
    logic [LANE_W-1:0] lane_idx;
    logic [7:0]        csum;
    logic [7:0]        lane_byte;
    logic              armed;
    logic              guard, guard_nx;
    logic              abort_pend;
    logic              start_cmd, abort_cmd, last_byte, to_idle;

    assign start_cmd = uart_rx_ready && (uart_data_from_rx == CMD_START);
    assign abort_cmd = uart_rx_ready && (uart_data_from_rx == CMD_ABORT);
    assign last_byte = (byte_idx == IDX_W'(NB - 1));

    // Word and lane are tracked as separate counters, so no divider is needed for odd lane counts
    always_comb begin
        lane_byte = ram_rdata[7:0];
        for (int i = 1; i < L; i++) begin
            if (lane_idx == LANE_W'(i)) lane_byte = ram_rdata[i*8 +: 8];
        end
    end

    always_comb begin
        state_nx       = state;
        guard_nx       = 1'b0;
        uart_tx_enable = 1'b0;
        case (state)
            INIT: begin
                // armed keeps enable low while reset is held
                if (armed && uart_tx_ready) begin
                    uart_tx_enable = 1'b1;
                    state_nx       = IDLE;
                end
            end
            IDLE:    if (start_cmd) state_nx = RD_ADDR;
            RD_ADDR: state_nx = RD_WAIT;
            RD_WAIT: state_nx = LOAD;
            LOAD:    state_nx = SEND;
            SEND: begin
                if (uart_tx_ready) begin
                    uart_tx_enable = 1'b1;
                    guard_nx       = 1'b1;
                    state_nx       = WAIT_FIN;
                end
            end
            WAIT_FIN: if (!guard && uart_tx_ready) state_nx = NEXT;
            NEXT: begin
                if (abort_pend)     state_nx = IDLE;
                else if (last_byte) state_nx = CSUM_EN ? CSUM : IDLE;
                else                state_nx = RD_ADDR;
            end
            CSUM: begin
                if (uart_tx_ready) begin
                    uart_tx_enable = 1'b1;
                    guard_nx       = 1'b1;
                    state_nx       = CSUM_WAIT;
                end
            end
            CSUM_WAIT: if (!guard && uart_tx_ready) state_nx = IDLE;
            default:   state_nx = INIT;
        endcase
    end

    assign to_idle = (state != IDLE) && (state != INIT) && (state_nx == IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= INIT;
            armed           <= 1'b0;
            guard           <= 1'b0;
            byte_idx        <= '0;
            lane_idx        <= '0;
            ram_raddr       <= '0;
            csum            <= '0;
            uart_data_to_tx <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            abort_pend      <= 1'b0;
        end else begin
            state <= state_nx;
            armed <= 1'b1;
            guard <= guard_nx;
            done  <= to_idle;
            if (to_idle) begin
                busy       <= 1'b0;
                abort_pend <= 1'b0;
            end else if (busy && abort_cmd) begin
                abort_pend <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start_cmd) begin
                        byte_idx  <= '0;
                        lane_idx  <= '0;
                        ram_raddr <= '0;
                        csum      <= '0;
                        busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    uart_data_to_tx <= lane_byte;
                    csum            <= csum ^ lane_byte;
                end
                NEXT: begin
                    if (state_nx == RD_ADDR) begin
                        byte_idx <= byte_idx + IDX_W'(1);
                        if (lane_idx == LANE_W'(L - 1)) begin
                            lane_idx  <= '0;
                            ram_raddr <= ram_raddr + ADDR_W'(1);
                        end else begin
                            lane_idx <= lane_idx + LANE_W'(1);
                        end
                    end else if (state_nx == CSUM) begin
                        // Loaded on entry so the byte is already stable when CSUM pulses enable
                        uart_data_to_tx <= csum;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
